// File: rtl/uart_link_pkg.sv
// Shared types and constants for the UART link arbiter: FSM state encoding,
// frame mode values and the frame width derivation.
package uart_link_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SEND  = 3'd1,
        WBUSY = 3'd2,
        WIDLE = 3'd3,
        WRSP  = 3'd4
    } state_e;

    localparam logic MODE_WRITE = 1'b1;
    localparam logic MODE_READ  = 1'b0;

    // Frame = {mode, wdata, addr}
    function automatic int frame_w(input int data_w, input int addr_w);
        return data_w + addr_w + 1;
    endfunction

endpackage

// File: rtl/uart_link_arbiter_rr.sv
// Combinational round-robin winner select: scans rr_ptr, rr_ptr+1, ... modulo
// NUM_REQ and returns the first requester with a pending frame.
module rr_arbiter #(
    parameter  int NUM_REQ = 2,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_valid_i,
    input  logic [IDX_W-1:0]   rr_ptr_i,
    output logic [IDX_W-1:0]   winner_idx_o,
    output logic               any_req_o
);

    logic [IDX_W:0] sum;

    // Walk offsets from far to near so the nearest valid requester wins last.
    always_comb begin
        winner_idx_o = '0;
        any_req_o    = 1'b0;
        sum          = '0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            sum = {1'b0, rr_ptr_i} + (IDX_W + 1)'(off);
            if (sum >= (IDX_W + 1)'(NUM_REQ))
                sum = sum - (IDX_W + 1)'(NUM_REQ);
            if (req_valid_i[sum[IDX_W-1:0]]) begin
                winner_idx_o = sum[IDX_W-1:0];
                any_req_o    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_link_arbiter.sv
// Shares one UART TX/RX pair among NUM_REQ bridge requesters: round-robin grant,
// one frame in flight, read data steered back to the issuer or a timeout reported.
module uart_link_arbiter
    import uart_link_pkg::*;
#(
    parameter  int NUM_REQ     = 2,
    parameter  int DATA_WIDTH  = 8,
    parameter  int ADDR_WIDTH  = 12,
    parameter  int RSP_TIMEOUT = 1000000,
    localparam int FRAME_W     = frame_w(DATA_WIDTH, ADDR_WIDTH)
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*FRAME_W-1:0] req_frame,
    output logic [NUM_REQ-1:0]         req_ack,
    output logic [NUM_REQ-1:0]         rsp_valid,
    output logic [DATA_WIDTH-1:0]      rsp_data,
    output logic                       rsp_err,
    output logic [FRAME_W-1:0]         u_din,
    output logic                       u_en,
    input  logic                       u_tx_busy,
    input  logic                       u_rx_ready,
    input  logic [DATA_WIDTH-1:0]      u_dout
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(RSP_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RSP_TIMEOUT - 1);

    state_e                state_q, state_d;
    logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]      owner_q, owner_d;
    logic [FRAME_W-1:0]    frame_q, frame_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [NUM_REQ-1:0]    req_ack_q, req_ack_d;
    logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic                  rsp_err_q, rsp_err_d;
    logic [FRAME_W-1:0]    u_din_q, u_din_d;
    logic                  u_en_q, u_en_d;

    logic [IDX_W-1:0]      winner_idx;
    logic                  any_req;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req_valid_i  (req_valid),
        .rr_ptr_i     (rr_ptr_q),
        .winner_idx_o (winner_idx),
        .any_req_o    (any_req)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            frame_q     <= '0;
            cnt_q       <= '0;
            req_ack_q   <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            u_din_q     <= '0;
            u_en_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            frame_q     <= frame_d;
            cnt_q       <= cnt_d;
            req_ack_q   <= req_ack_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            u_din_q     <= u_din_d;
            u_en_q      <= u_en_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        frame_d     = frame_q;
        cnt_d       = cnt_q;
        u_din_d     = u_din_q;
        req_ack_d   = '0;
        rsp_valid_d = '0;
        rsp_data_d  = '0;
        rsp_err_d   = 1'b0;
        u_en_d      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    owner_d               = winner_idx;
                    frame_d               = req_frame[int'(winner_idx)*FRAME_W +: FRAME_W];
                    req_ack_d[winner_idx] = 1'b1;
                    rr_ptr_d = (winner_idx == IDX_W'(NUM_REQ - 1)) ? '0 : winner_idx + 1'b1;
                    state_d  = SEND;
                end
            end
            SEND: begin
                u_din_d = frame_q;
                u_en_d  = 1'b1;
                state_d = WBUSY;
            end
            WBUSY: begin
                if (u_tx_busy) state_d = WIDLE;
            end
            WIDLE: begin
                if (!u_tx_busy) begin
                    if (frame_q[FRAME_W-1] == MODE_WRITE) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d   = '0;
                        state_d = WRSP;
                    end
                end
            end
            WRSP: begin
                // Data arriving on the expiry cycle still counts as a good read.
                if (u_rx_ready) begin
                    rsp_valid_d[owner_q] = 1'b1;
                    rsp_data_d           = u_dout;
                    state_d              = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    rsp_valid_d[owner_q] = 1'b1;
                    rsp_err_d            = 1'b1;
                    state_d              = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign req_ack   = req_ack_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign u_din     = u_din_q;
    assign u_en      = u_en_q;

endmodule

// File: tb/tb_uart_link_arbiter.sv
// Scoreboard bench for uart_link_arbiter: a grant-order model predicts acks,
// transmitted frames and read responses; a monitor checks them as they appear.
module tb_uart_link_arbiter;
    localparam int NR = 3, DW = 8, AW = 12, T = 16, FW = DW + AW + 1;

    logic              clk = 1'b0, rstn = 1'b0;
    logic [NR-1:0]     req_valid = '0;
    logic [NR*FW-1:0]  req_frame = '0;
    logic [NR-1:0]     req_ack, rsp_valid;
    logic [DW-1:0]     rsp_data;
    logic              rsp_err;
    logic [FW-1:0]     u_din;
    logic              u_en;
    logic              u_tx_busy = 1'b0, u_rx_ready = 1'b0;
    logic [DW-1:0]     u_dout = '0;

    always #5 clk = ~clk;

    uart_link_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RSP_TIMEOUT(T)) dut (
        .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_frame(req_frame),
        .req_ack(req_ack), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .u_din(u_din), .u_en(u_en), .u_tx_busy(u_tx_busy), .u_rx_ready(u_rx_ready), .u_dout(u_dout)
    );

    typedef struct { int idx; int cyc; } ack_t;
    typedef struct { logic [FW-1:0] frame; int cyc; } tx_t;
    typedef struct { int idx; logic [DW-1:0] data; logic err; } rsp_t;
    // k = cycles after busy falls until rx_ready is raised; 0 = never (timeout)
    typedef struct { logic [FW-1:0] frame; logic rd; int k; logic [DW-1:0] data; } plan_t;

    ack_t  exp_ack[$];
    tx_t   exp_tx[$];
    rsp_t  exp_rsp[$];
    int    exp_rsp_cyc[$];
    plan_t uplan[$];
    plan_t rq[NR][$];

    int total = 0, bad = 0, cyc = 0, m_ptr = 0, uart_left = 0;
    bit auto_uart = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every DUT output event pops and checks the next expectation.
    always @(negedge clk) begin : mon
        ack_t ea; tx_t et; rsp_t er; int ec; logic [NR-1:0] oh;
        if (rstn) begin
            if (req_ack != '0) begin
                total++;
                if (exp_ack.size() == 0) begin
                    bad++; $display("FAIL ack_unexpected got=%b cyc=%0d", req_ack, cyc);
                end else begin
                    ea = exp_ack.pop_front(); oh = '0; oh[ea.idx] = 1'b1;
                    if (req_ack != oh || (ea.cyc >= 0 && ea.cyc != cyc)) begin
                        bad++; $display("FAIL ack got=%b@%0d want=%b@%0d", req_ack, cyc, oh, ea.cyc);
                    end
                end
            end
            if (u_en) begin
                total++;
                if (exp_tx.size() == 0) begin
                    bad++; $display("FAIL tx_unexpected got=%h cyc=%0d", u_din, cyc);
                end else begin
                    et = exp_tx.pop_front();
                    if (u_din !== et.frame || (et.cyc >= 0 && et.cyc != cyc)) begin
                        bad++; $display("FAIL tx got=%h@%0d want=%h@%0d", u_din, cyc, et.frame, et.cyc);
                    end
                end
            end
            if (rsp_valid != '0) begin
                total++;
                if (exp_rsp.size() == 0) begin
                    bad++; $display("FAIL rsp_unexpected got=%b cyc=%0d", rsp_valid, cyc);
                end else begin
                    er = exp_rsp.pop_front(); oh = '0; oh[er.idx] = 1'b1;
                    ec = (exp_rsp_cyc.size() > 0) ? exp_rsp_cyc.pop_front() : -1;
                    if (rsp_valid != oh || rsp_data !== er.data || rsp_err !== er.err || ec != cyc) begin
                        bad++;
                        $display("FAIL rsp got=%b/%h/err%b@%0d want=%b/%h/err%b@%0d",
                                 rsp_valid, rsp_data, rsp_err, cyc, oh, er.data, er.err, ec);
                    end
                end
            end
        end
    end

    // UART model: busy after a random delay, optional stray byte while busy,
    // then the planned read byte (or silence) once the line is idle.
    initial begin : uart_model
        plan_t p; int c0, h;
        forever begin
            @(negedge clk);
            if (auto_uart && u_en && uplan.size() > 0) begin
                p = uplan.pop_front();
                repeat ($urandom_range(0, 3)) @(negedge clk);
                u_tx_busy = 1'b1;
                h = $urandom_range(1, 4);
                for (int s = 0; s < h; s++) begin
                    if (s == 0 && $urandom_range(0, 2) == 0) begin
                        u_rx_ready = 1'b1; u_dout = DW'($urandom);
                    end else u_rx_ready = 1'b0;
                    @(negedge clk);
                end
                u_rx_ready = 1'b0; u_tx_busy = 1'b0; c0 = cyc;
                if (p.rd) begin
                    if (p.k > 0) begin
                        exp_rsp_cyc.push_back(c0 + 1 + p.k);
                        repeat (p.k) @(negedge clk);
                        u_rx_ready = 1'b1; u_dout = p.data;
                        @(negedge clk);
                        u_rx_ready = 1'b0;
                    end else exp_rsp_cyc.push_back(c0 + 1 + T);
                end
                uart_left--;
            end
        end
    end

    function automatic plan_t mk(input logic [FW-1:0] f, input int k, input logic [DW-1:0] d);
        plan_t p;
        p.frame = f; p.rd = ~f[FW-1]; p.k = k; p.data = d;
        return p;
    endfunction

    function automatic logic [FW-1:0] rnd_frame();
        logic [31:0] r;
        r = $urandom;
        return r[FW-1:0];
    endfunction

    function automatic int rr_pick(input int rem[NR]);
        for (int o = 0; o < NR; o++)
            if (rem[(m_ptr + o) % NR] > 0) return (m_ptr + o) % NR;
        return -1;
    endfunction

    // Present every queued frame; the model predicts the complete grant order.
    task automatic run_round(input string name);
        int rem[NR]; int w, cs, left; bit first, done; plan_t p;
        @(negedge clk);
        cs = cyc; first = 1'b1; left = 0;
        for (int i = 0; i < NR; i++) begin rem[i] = rq[i].size(); left += rem[i]; end
        uart_left = left;
        while (left > 0) begin
            w = rr_pick(rem);
            p = rq[w][rq[w].size() - rem[w]];
            exp_ack.push_back('{w, first ? cs + 1 : -1});
            exp_tx.push_back('{p.frame, first ? cs + 2 : -1});
            uplan.push_back(p);
            if (p.rd) exp_rsp.push_back('{w, (p.k > 0) ? p.data : '0, p.k == 0});
            rem[w]--; left--; m_ptr = (w + 1) % NR; first = 1'b0;
        end
        for (int i = 0; i < NR; i++)
            if (rq[i].size() > 0) begin req_valid[i] = 1'b1; req_frame[i*FW +: FW] = rq[i][0].frame; end
        done = 1'b0;
        for (int c = 0; c < 3000 && !done; c++) begin
            @(negedge clk);
            for (int i = 0; i < NR; i++)
                if (req_ack[i] && rq[i].size() > 0) begin
                    void'(rq[i].pop_front());
                    if (rq[i].size() > 0) req_frame[i*FW +: FW] = rq[i][0].frame;
                    else begin req_valid[i] = 1'b0; req_frame[i*FW +: FW] = rnd_frame(); end
                end
            done = (exp_ack.size() == 0 && exp_tx.size() == 0 && exp_rsp.size() == 0 && uart_left == 0);
            for (int i = 0; i < NR; i++) if (rq[i].size() > 0) done = 1'b0;
        end
        total++;
        if (!done) begin
            bad++; $display("FAIL %s drained=%0d want=1 (ack=%0d tx=%0d rsp=%0d)", name, done,
                            exp_ack.size(), exp_tx.size(), exp_rsp.size());
            exp_ack.delete(); exp_tx.delete(); exp_rsp.delete(); exp_rsp_cyc.delete(); uplan.delete();
            for (int i = 0; i < NR; i++) begin rq[i].delete(); req_valid[i] = 1'b0; end
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic check_zero(input string name);
        total++;
        if ({req_ack, rsp_valid, rsp_data, rsp_err, u_din, u_en} != '0) begin
            bad++;
            $display("FAIL %s ack=%b rv=%b rd=%h re=%b din=%h en=%b want all 0",
                     name, req_ack, rsp_valid, rsp_data, rsp_err, u_din, u_en);
        end
    endtask

    // One grant driven by hand, no UART model; returns once u_en has been seen.
    task automatic manual_grant(input int idx, input logic [FW-1:0] f);
        int cs;
        @(negedge clk);
        cs = cyc;
        exp_ack.push_back('{idx, cs + 1});
        exp_tx.push_back('{f, cs + 2});
        m_ptr = (idx + 1) % NR;
        req_valid[idx] = 1'b1; req_frame[idx*FW +: FW] = f;
        @(negedge clk); req_valid[idx] = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_zero("reset_outputs");
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        rq[0].push_back(mk(21'h1A5123, 0, 8'h00));
        run_round("single_write");
        rq[1].push_back(mk({1'b0, 8'h00, 12'h0F0}, 3, 8'h3C));
        run_round("read_req1");
        for (int n = 0; n < 2; n++) begin
            rq[0].push_back(mk({1'b1, 8'(8'h10 + n), 12'h100}, 0, 8'h00));
            rq[1].push_back(mk({1'b1, 8'(8'h20 + n), 12'h200}, 0, 8'h00));
        end
        run_round("alternate_writes");
        rq[2].push_back(mk({1'b0, 8'h00, 12'h7E7}, 0, 8'hAA));
        run_round("read_timeout");
        rq[0].push_back(mk({1'b0, 8'h00, 12'h055}, T, 8'h5A));
        run_round("data_at_expiry");

        for (int r = 0; r < 12; r++) begin
            for (int i = 0; i < NR; i++)
                repeat ($urandom_range(0, 2))
                    rq[i].push_back(mk(rnd_frame(), ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, T),
                                       DW'($urandom)));
            if (rq[0].size() + rq[1].size() + rq[2].size() == 0)
                rq[0].push_back(mk(rnd_frame(), 1, DW'($urandom)));
            run_round("random_round");
        end

        // Reset during WBUSY: the write is dropped mid-flight.
        auto_uart = 1'b0;
        manual_grant(1, {1'b1, 8'hC3, 12'h321});
        @(negedge clk); rstn = 1'b0;
        @(negedge clk); check_zero("reset_in_wbusy"); rstn = 1'b1; m_ptr = 0;
        repeat (2) @(negedge clk);

        // Reset during WRSP: no response may follow, even if a byte arrives later.
        manual_grant(1, {1'b0, 8'h00, 12'h0AB});
        u_tx_busy = 1'b1;
        @(negedge clk); u_tx_busy = 1'b0;
        repeat (3) @(negedge clk); rstn = 1'b0;
        @(negedge clk); check_zero("reset_in_wrsp"); rstn = 1'b1; m_ptr = 0;
        u_rx_ready = 1'b1; u_dout = 8'hFF;
        repeat (2) @(negedge clk); u_rx_ready = 1'b0;
        repeat (3) @(negedge clk);
        auto_uart = 1'b1;

        rq[0].push_back(mk({1'b1, 8'h01, 12'h001}, 0, 8'h00));
        rq[1].push_back(mk({1'b1, 8'h02, 12'h002}, 0, 8'h00));
        run_round("grant_after_reset");

        total++;
        if (exp_ack.size() + exp_tx.size() + exp_rsp.size() != 0) begin
            bad++; $display("FAIL leftover_expectations got=%0d want=0",
                            exp_ack.size() + exp_tx.size() + exp_rsp.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout cyc=%0d", cyc);
        $fatal(1, "bench timeout");
    end
endmodule
